// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the two-bank SRAM arbiter.
// Bank decode values, bank FSM states, requester ids and the latched request record.
package sram_arbiter_pkg;

  localparam logic [9:0]  BASE_BANK           = 10'h200;
  localparam logic [9:0]  EXT_BANK            = 10'h201;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } bank_state_e;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  // Request fields latched by a bank on grant; the word address travels separately.
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    req_id_e     id;
  } bank_req_t;

  function automatic logic addr_in_bank(input logic [31:0] addr, input logic [9:0] bank);
    return addr[31:22] == bank;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes and SRAM pad bundles for the arbiter.
// slave is the arbiter's view; master is the pipeline/board side.
interface sram_arbiter_if #(
  parameter int unsigned SRAM_AW = 20
);

  logic               if_req;
  logic [31:0]        if_addr;
  logic               if_ack;
  logic [31:0]        if_rdata;

  logic               mem_req;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [3:0]         mem_sel;
  logic [31:0]        mem_wdata;
  logic               mem_ack;
  logic [31:0]        mem_rdata;

  logic [SRAM_AW-1:0] base_ram_addr;
  logic [31:0]        base_ram_wdata;
  logic [31:0]        base_ram_rdata;
  logic               base_ram_data_oe;
  logic               base_ram_ce_n;
  logic               base_ram_oe_n;
  logic               base_ram_we_n;
  logic [3:0]         base_ram_be_n;

  logic [SRAM_AW-1:0] ext_ram_addr;
  logic [31:0]        ext_ram_wdata;
  logic [31:0]        ext_ram_rdata;
  logic               ext_ram_data_oe;
  logic               ext_ram_ce_n;
  logic               ext_ram_oe_n;
  logic               ext_ram_we_n;
  logic [3:0]         ext_ram_be_n;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    input  base_ram_rdata, ext_ram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata,
    output base_ram_addr, base_ram_wdata, base_ram_data_oe, base_ram_ce_n, base_ram_oe_n,
    output base_ram_we_n, base_ram_be_n,
    output ext_ram_addr, ext_ram_wdata, ext_ram_data_oe, ext_ram_ce_n, ext_ram_oe_n,
    output ext_ram_we_n, ext_ram_be_n
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    output base_ram_rdata, ext_ram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata,
    input  base_ram_addr, base_ram_wdata, base_ram_data_oe, base_ram_ce_n, base_ram_oe_n,
    input  base_ram_we_n, base_ram_be_n,
    input  ext_ram_addr, ext_ram_wdata, ext_ram_data_oe, ext_ram_ce_n, ext_ram_oe_n,
    input  ext_ram_we_n, ext_ram_be_n
  );

endinterface

// File: rtl/sram_bank_ctrl.sv
// One SRAM bank: latches a granted request, sequences the pads for WAIT_CYCLES
// access cycles, then acks for one cycle tagged with the requester id.
module sram_bank_ctrl
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  input  logic [SRAM_AW-1:0] req_addr_i,
  input  bank_req_t          req_i,
  output logic               ack_o,
  output req_id_e            ack_id_o,
  output logic [31:0]        rdata_o,
  output logic [SRAM_AW-1:0] ram_addr_o,
  output logic [31:0]        ram_wdata_o,
  input  logic [31:0]        ram_rdata_i,
  output logic               ram_data_oe_o,
  output logic               ram_ce_n_o,
  output logic               ram_oe_n_o,
  output logic               ram_we_n_o,
  output logic [3:0]         ram_be_n_o
);

  localparam int unsigned     CntW    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_CYCLES);

  bank_state_e        state_q, state_d;
  bank_req_t          req_q, req_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    ack_o         = 1'b0;
    rdata_o       = '0;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;
    ram_data_oe_o = 1'b0;
    ram_ce_n_o    = 1'b1;
    ram_oe_n_o    = 1'b1;
    ram_we_n_o    = 1'b1;
    ram_be_n_o    = 4'hF;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          req_d   = req_i;
          addr_d  = req_addr_i;
          cnt_d   = CntW'(1);
          rdata_d = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        ram_ce_n_o = 1'b0;
        ram_be_n_o = ~req_q.sel;
        ram_addr_o = addr_q;
        if (req_q.we) begin
          ram_we_n_o    = 1'b0;
          ram_data_oe_o = 1'b1;
          ram_wdata_o   = req_q.wdata;
        end else begin
          ram_oe_n_o = 1'b0;
        end
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (!req_q.we) rdata_d = ram_rdata_i;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        ack_o      = 1'b1;
        rdata_o    = rdata_q;
        ram_addr_o = addr_q;
        // Keep driving write data one cycle past we_n rising for hold time.
        if (req_q.we) begin
          ram_data_oe_o = 1'b1;
          ram_wdata_o   = req_q.wdata;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ack_id_o = req_q.id;

endmodule

// File: rtl/sram_arbiter.sv
// Shares the base and ext SRAM banks between instruction fetch and the MEM stage.
// Decodes to a bank, gives data priority on same-bank conflicts, acks unmapped accesses.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = 20
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  logic if_base, if_ext, if_unmapped;
  logic mem_base, mem_ext, mem_unmapped;

  assign if_base      = addr_in_bank(bus.if_addr, BASE_BANK);
  assign if_ext       = addr_in_bank(bus.if_addr, EXT_BANK);
  assign if_unmapped  = !(if_base || if_ext);
  assign mem_base     = addr_in_bank(bus.mem_addr, BASE_BANK);
  assign mem_ext      = addr_in_bank(bus.mem_addr, EXT_BANK);
  assign mem_unmapped = !(mem_base || mem_ext);

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

  // Reads always fetch the full word; lane extraction happens in the MEM stage.
  bank_req_t if_bank_req, mem_bank_req;
  assign if_bank_req  = '{we: 1'b0, sel: 4'hF, wdata: 32'h0, id: REQ_IF};
  assign mem_bank_req = '{we: bus.mem_we, sel: (bus.mem_we ? bus.mem_sel : 4'hF),
                          wdata: bus.mem_wdata, id: REQ_MEM};

  logic               base_take_mem, ext_take_mem, base_valid, ext_valid;
  bank_req_t          base_req, ext_req;
  logic [SRAM_AW-1:0] base_addr, ext_addr;

  assign base_take_mem = bus.mem_req && mem_base;
  assign ext_take_mem  = bus.mem_req && mem_ext;
  assign base_valid    = base_take_mem || (bus.if_req && if_base);
  assign ext_valid     = ext_take_mem || (bus.if_req && if_ext);
  assign base_req      = base_take_mem ? mem_bank_req : if_bank_req;
  assign ext_req       = ext_take_mem ? mem_bank_req : if_bank_req;
  assign base_addr     = base_take_mem ? bus.mem_addr[SRAM_AW+1:2] : bus.if_addr[SRAM_AW+1:2];
  assign ext_addr      = ext_take_mem ? bus.mem_addr[SRAM_AW+1:2] : bus.if_addr[SRAM_AW+1:2];

  logic        base_ack, ext_ack;
  req_id_e     base_ack_id, ext_ack_id;
  logic [31:0] base_rdata, ext_rdata;

  sram_bank_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .SRAM_AW    (SRAM_AW)
  ) u_base (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (base_valid),
    .req_addr_i   (base_addr),
    .req_i        (base_req),
    .ack_o        (base_ack),
    .ack_id_o     (base_ack_id),
    .rdata_o      (base_rdata),
    .ram_addr_o   (bus.base_ram_addr),
    .ram_wdata_o  (bus.base_ram_wdata),
    .ram_rdata_i  (bus.base_ram_rdata),
    .ram_data_oe_o(bus.base_ram_data_oe),
    .ram_ce_n_o   (bus.base_ram_ce_n),
    .ram_oe_n_o   (bus.base_ram_oe_n),
    .ram_we_n_o   (bus.base_ram_we_n),
    .ram_be_n_o   (bus.base_ram_be_n)
  );

  sram_bank_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .SRAM_AW    (SRAM_AW)
  ) u_ext (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (ext_valid),
    .req_addr_i   (ext_addr),
    .req_i        (ext_req),
    .ack_o        (ext_ack),
    .ack_id_o     (ext_ack_id),
    .rdata_o      (ext_rdata),
    .ram_addr_o   (bus.ext_ram_addr),
    .ram_wdata_o  (bus.ext_ram_wdata),
    .ram_rdata_i  (bus.ext_ram_rdata),
    .ram_data_oe_o(bus.ext_ram_data_oe),
    .ram_ce_n_o   (bus.ext_ram_ce_n),
    .ram_oe_n_o   (bus.ext_ram_oe_n),
    .ram_we_n_o   (bus.ext_ram_we_n),
    .ram_be_n_o   (bus.ext_ram_be_n)
  );

  // The ack flag blocks resampling the still-held request during its own ack cycle.
  logic if_unm_ack_q, mem_unm_ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_unm_ack_q  <= 1'b0;
      mem_unm_ack_q <= 1'b0;
    end else begin
      if_unm_ack_q  <= bus.if_req && if_unmapped && !if_unm_ack_q;
      mem_unm_ack_q <= bus.mem_req && mem_unmapped && !mem_unm_ack_q;
    end
  end

  always_comb begin
    bus.if_ack    = if_unm_ack_q;
    bus.if_rdata  = '0;
    bus.mem_ack   = mem_unm_ack_q;
    bus.mem_rdata = '0;
    if (base_ack) begin
      if (base_ack_id == REQ_MEM) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = base_rdata;
      end else begin
        bus.if_ack   = 1'b1;
        bus.if_rdata = base_rdata;
      end
    end
    if (ext_ack) begin
      if (ext_ack_id == REQ_MEM) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = ext_rdata;
      end else begin
        bus.if_ack   = 1'b1;
        bus.if_rdata = ext_rdata;
      end
    end
  end

endmodule
